// File: rtl/event_encoder_4to2.sv
// Captures single-cycle event pulses on four lines and replays them one at a time
// as a 2-bit index over a valid/ready handshake (fixed priority or round-robin).
module event_encoder_4to2 #(
    parameter bit RR = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in,
    input  logic       ready,
    output logic [1:0] out,
    output logic       valid,
    output logic       overflow,
    output logic [3:0] pending,
    output logic [2:0] pend_cnt
);

    logic [1:0] ptr;
    logic [1:0] sel;
    logic       load;
    logic [3:0] load_mask;

    function automatic logic [1:0] pick_fixed(input logic [3:0] p);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (p[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Scan from ptr+4 (ptr itself, lowest priority) down to ptr+1 so the
    // nearest index after the last grant overwrites everything else.
    function automatic logic [1:0] pick_rr(input logic [3:0] p, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] cand;
        idx = last;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (p[cand]) idx = cand;
        end
        return idx;
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] p);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + 3'(p[i]);
        end
        return n;
    endfunction

    always_comb begin
        sel       = RR ? pick_rr(pending, ptr) : pick_fixed(pending);
        load      = (!valid || ready) && (pending != 4'b0000);
        load_mask = load ? (4'b0001 << sel) : 4'b0000;
        pend_cnt  = popcount4(pending);
    end

    // A bit being granted and re-armed on the same edge stays set without
    // flagging overflow: the new event is a fresh one, not a lost one.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= 4'b0000;
            out      <= 2'b00;
            valid    <= 1'b0;
            overflow <= 1'b0;
            ptr      <= 2'b11;
        end else begin
            pending  <= (pending & ~load_mask) | in;
            overflow <= |(in & pending & ~load_mask);
            if (load) begin
                out   <= sel;
                valid <= 1'b1;
                ptr   <= sel;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_event_encoder_4to2.sv
// Bench for event_encoder_4to2: a fixed-priority and a round-robin instance share
// stimulus and are compared against a cycle-level behavioural model.
module tb_event_encoder_4to2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in = 4'b0000;
    logic       ready = 1'b0;

    logic [1:0] o_out [2];
    logic       o_valid [2];
    logic       o_ovf [2];
    logic [3:0] o_pend [2];
    logic [2:0] o_cnt [2];

    logic [7:0] st0, st1;
    assign st0 = {o_valid[0], o_out[0], o_ovf[0], o_pend[0]};
    assign st1 = {o_valid[1], o_out[1], o_ovf[1], o_pend[1]};

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] m_pend [2];
    logic [1:0] m_out [2];
    logic [1:0] m_ptr [2];
    logic       m_valid [2];
    logic       m_ovf [2];

    always #5 clk = ~clk;

    event_encoder_4to2 #(.RR(1'b0)) dut_fp (
        .clk(clk), .rst(rst), .in(in), .ready(ready),
        .out(o_out[0]), .valid(o_valid[0]), .overflow(o_ovf[0]),
        .pending(o_pend[0]), .pend_cnt(o_cnt[0])
    );

    event_encoder_4to2 #(.RR(1'b1)) dut_rr (
        .clk(clk), .rst(rst), .in(in), .ready(ready),
        .out(o_out[1]), .valid(o_valid[1]), .overflow(o_ovf[1]),
        .pending(o_pend[1]), .pend_cnt(o_cnt[1])
    );

    // Model: set of outstanding event indices plus the offered slot.
    task automatic model_step(input int m, input logic [3:0] i, input logic r, input logic rs);
        logic [3:0] p;
        int         pick;
        int         j;
        bit         found;
        bit         ld;
        if (rs) begin
            m_pend[m] = 4'b0000; m_out[m] = 2'b00; m_valid[m] = 1'b0;
            m_ovf[m] = 1'b0; m_ptr[m] = 2'b11;
        end else begin
            p = m_pend[m];
            pick = 0;
            found = 0;
            for (int k = 0; k < 4; k++) begin
                j = (m == 1) ? (int'(m_ptr[m]) + 1 + k) % 4 : k;
                if (!found && p[j]) begin
                    found = 1;
                    pick = j;
                end
            end
            ld = found && (!m_valid[m] || r);
            if (ld) p[pick] = 1'b0;
            m_ovf[m] = |(i & p);
            m_pend[m] = p | i;
            if (ld) begin
                m_out[m] = 2'(pick);
                m_valid[m] = 1'b1;
                m_ptr[m] = 2'(pick);
            end else if (m_valid[m] && r) begin
                m_valid[m] = 1'b0;
            end
        end
    endtask

    task automatic tick(input logic [3:0] i, input logic r);
        in = i;
        ready = r;
        @(posedge clk);
        for (int m = 0; m < 2; m++) model_step(m, i, r, rst);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(4'b1111, 1'b1);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] e;
        rst = 1'b1;
        tick(4'b0000, 1'b0);
        tick(4'b1010, 1'b1);
        rst = 1'b0;
        e = 11'b0;
        vectors++;
        if ({st0, o_cnt[0]} !== e || {st1, o_cnt[1]} !== e) begin
            miscompares++;
            $display("FAIL reset_state got=%b/%b want=%b", {st0, o_cnt[0]}, {st1, o_cnt[1]}, e);
        end
    endtask

    task automatic test_single();
        logic [7:0] e [3];
        e[0] = 8'b0_00_0_0100;
        e[1] = 8'b1_10_0_0000;
        e[2] = 8'b0_10_0_0000;
        do_reset();
        for (int s = 0; s < 3; s++) begin
            tick((s == 0) ? 4'b0100 : 4'b0000, 1'b1);
            vectors++;
            if ({st0, st1} !== {e[s], e[s]}) begin
                miscompares++;
                $display("FAIL single_event step%0d got=%b/%b want=%b", s, st0, st1, e[s]);
            end
        end
    endtask

    task automatic test_fixed_burst();
        logic [10:0] e [5];
        e[0] = {8'b0_00_0_1011, 3'd3};
        e[1] = {8'b1_00_0_1010, 3'd2};
        e[2] = {8'b1_01_0_1000, 3'd1};
        e[3] = {8'b1_11_0_0000, 3'd0};
        e[4] = {8'b0_11_0_0000, 3'd0};
        do_reset();
        for (int s = 0; s < 5; s++) begin
            tick((s == 0) ? 4'b1011 : 4'b0000, 1'b1);
            vectors++;
            if ({st0, o_cnt[0]} !== e[s]) begin
                miscompares++;
                $display("FAIL fixed_burst step%0d got=%b want=%b", s, {st0, o_cnt[0]}, e[s]);
            end
        end
    endtask

    task automatic test_rr_vs_fixed();
        logic [7:0] e0 [5];
        logic [7:0] e1 [5];
        logic [3:0] stim [5];
        stim[0] = 4'b0001; stim[1] = 4'b0000; stim[2] = 4'b0011; stim[3] = 4'b0000; stim[4] = 4'b0000;
        e0[0] = 8'b0_00_0_0001; e1[0] = 8'b0_00_0_0001;
        e0[1] = 8'b1_00_0_0000; e1[1] = 8'b1_00_0_0000;
        e0[2] = 8'b0_00_0_0011; e1[2] = 8'b0_00_0_0011;
        e0[3] = 8'b1_00_0_0010; e1[3] = 8'b1_01_0_0001;
        e0[4] = 8'b1_01_0_0000; e1[4] = 8'b1_00_0_0000;
        do_reset();
        for (int s = 0; s < 5; s++) begin
            tick(stim[s], 1'b1);
            vectors++;
            if ({st0, st1} !== {e0[s], e1[s]}) begin
                miscompares++;
                $display("FAIL rr_vs_fixed step%0d got fp=%b rr=%b want fp=%b rr=%b",
                         s, st0, st1, e0[s], e1[s]);
            end
        end
    endtask

    task automatic test_hold_overflow();
        logic [7:0] e [10];
        logic [3:0] stim [10];
        logic       rdy [10];
        stim[0] = 4'b0001; rdy[0] = 0; e[0] = 8'b0_00_0_0001;
        stim[1] = 4'b0000; rdy[1] = 0; e[1] = 8'b1_00_0_0000;
        stim[2] = 4'b0010; rdy[2] = 0; e[2] = 8'b1_00_0_0010;
        stim[3] = 4'b0000; rdy[3] = 0; e[3] = 8'b1_00_0_0010;
        stim[4] = 4'b0000; rdy[4] = 0; e[4] = 8'b1_00_0_0010;
        stim[5] = 4'b0010; rdy[5] = 0; e[5] = 8'b1_00_1_0010;
        stim[6] = 4'b0000; rdy[6] = 0; e[6] = 8'b1_00_0_0010;
        stim[7] = 4'b0000; rdy[7] = 1; e[7] = 8'b1_01_0_0000;
        stim[8] = 4'b0000; rdy[8] = 1; e[8] = 8'b0_01_0_0000;
        stim[9] = 4'b0000; rdy[9] = 1; e[9] = 8'b0_01_0_0000;
        do_reset();
        for (int s = 0; s < 10; s++) begin
            tick(stim[s], rdy[s]);
            vectors++;
            if ({st0, st1} !== {e[s], e[s]}) begin
                miscompares++;
                $display("FAIL hold_overflow step%0d got=%b/%b want=%b", s, st0, st1, e[s]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] e;
        do_reset();
        tick(4'b1000, 1'b0);
        tick(4'b0000, 1'b0);
        tick(4'b1110, 1'b0);
        e = 8'b1_11_0_1110;
        vectors++;
        if ({st0, st1} !== {e, e}) begin
            miscompares++;
            $display("FAIL reset_mid_setup got=%b/%b want=%b", st0, st1, e);
        end
        rst = 1'b1;
        tick(4'b1111, 1'b1);
        rst = 1'b0;
        e = 8'b0;
        vectors++;
        if ({st0, st1} !== {e, e}) begin
            miscompares++;
            $display("FAIL reset_mid_clear got=%b/%b want=%b", st0, st1, e);
        end
        for (int s = 0; s < 10; s++) begin
            tick(4'b0000, 1'b1);
            vectors++;
            if (o_valid[0] !== 1'b0 || o_valid[1] !== 1'b0 || o_pend[0] !== 4'b0 || o_pend[1] !== 4'b0) begin
                miscompares++;
                $display("FAIL reset_mid_quiet cycle%0d got valid=%b%b pend=%b/%b want 00 0000",
                         s, o_valid[0], o_valid[1], o_pend[0], o_pend[1]);
            end
        end
    endtask

    task automatic test_same_bit();
        logic [7:0] e [4];
        logic [3:0] stim [4];
        stim[0] = 4'b0100; e[0] = 8'b0_00_0_0100;
        stim[1] = 4'b0100; e[1] = 8'b1_10_0_0100;
        stim[2] = 4'b0000; e[2] = 8'b1_10_0_0000;
        stim[3] = 4'b0000; e[3] = 8'b0_10_0_0000;
        do_reset();
        for (int s = 0; s < 4; s++) begin
            tick(stim[s], 1'b1);
            vectors++;
            if ({st0, st1} !== {e[s], e[s]}) begin
                miscompares++;
                $display("FAIL same_bit step%0d got=%b/%b want=%b", s, st0, st1, e[s]);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] ri;
        logic       rr;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            ri = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            rr = (c < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 99) == 0);
            tick(ri, rr);
            for (int m = 0; m < 2; m++) begin
                vectors++;
                if ({o_valid[m], o_out[m], o_ovf[m], o_pend[m], o_cnt[m]} !==
                    {m_valid[m], m_out[m], m_ovf[m], m_pend[m], 3'($countones(m_pend[m]))}) begin
                    miscompares++;
                    $display("FAIL random inst%0d cycle%0d got v=%b o=%b ov=%b p=%b n=%0d want v=%b o=%b ov=%b p=%b",
                             m, c, o_valid[m], o_out[m], o_ovf[m], o_pend[m], o_cnt[m],
                             m_valid[m], m_out[m], m_ovf[m], m_pend[m]);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_fixed_burst();
        test_rr_vs_fixed();
        test_hold_overflow();
        test_reset_mid();
        test_same_bit();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/event_encoder_4to2.md
# event_encoder_4to2

Sequential 4-to-2 encoder that runs in the opposite direction to the 2-to-4 decoder. It captures single-cycle event pulses on four request lines and holds each one as pending. Pending events are emitted one at a time as a 2-bit index over a valid/ready handshake. It sits between raw one-hot event sources and any consumer that needs a compact index stream, typically feeding a 2-to-4 decoder on the far side.

## Interface
- RR, default 0: 0 selects fixed priority (index 0 highest); 1 selects round-robin.
- clk, input, 1: single clock; every register updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in, input, 4: event pulses; bit i high for one cycle means one event on index i; multi-hot allowed.
- ready, input, 1: the consumer accepts `out` on any edge where valid && ready.
- out, output, 2: encoded index of the event currently offered; registered.
- valid, output, 1: `out` holds an event; registered.
- overflow, output, 1: one-cycle registered pulse; an event merged into an already-pending bit.
- pending, output, 4: pending-event register, direct view.
- pend_cnt, output, 3: popcount of `pending` (0..4), combinational from the register.

## Operation
- State: pending[3:0], output register {valid, out}, RR pointer ptr[1:0].
- Selection uses the registered `pending` only, never raw `in`.
- Fixed priority: lowest set index wins.
- Round-robin: search starts at ptr+1 and wraps 3 to 0; ptr updates to the loaded index on every load.
- Load condition: (!valid || ready) && pending != 0.
  - On load: out <= selected index, valid <= 1, and the selected pending bit is cleared.
- Drain condition: valid && ready && pending == 0 gives valid <= 0; `out` keeps its last value.
- Hold: valid && !ready keeps `out` and `valid` unchanged and blocks any load.
- Pending update: pending <= (pending & ~load_mask) | in.
- Overflow: overflow <= |(in & pending & ~load_mask).
  - The event is merged into the pending bit, so one event is lost.
- Simultaneous set and load on the same bit: the bit stays 1, overflow stays 0, and a second grant follows later.
- Reset values:
  - pending = 0000, out = 00, valid = 0, overflow = 0, ptr = 11 (so the first RR search starts at 0), pend_cnt = 0.
- `in` is ignored on reset edges.
- Reset mid-operation discards all pending events and any offered event. No grant appears afterward without new input.

## Timing
- Latency: `in` sampled at edge t, then pending set after edge t, then load at edge t+1. Valid is high 2 cycles after the input pulse.
- Throughput: one grant per cycle with ready held high. There is no bubble between back-to-back grants.
- `out` is stable from the edge valid rises until the edge where valid && ready.
- `overflow` is high for exactly the one cycle after the offending edge.
- No combinational path from `in` or `ready` to any output except `pend_cnt`, which follows the `pending` register.

## Test plan
1. Reset, ready=1, in=0100 for one cycle → 2 cycles later valid=1 with out=10 for exactly one cycle, then valid=0; overflow never asserts.
2. RR=0, ready=1, in=1011 for one cycle → grants out=00, 01, 11 on three consecutive cycles; pend_cnt steps 3, 2, 1, 0.
3. RR=1, ready=1: pulse in=0001 (grant 00), then pulse in=0011 → grants 01 then 00. The same stimulus with RR=0 → grants 00 then 01.
4. ready=0 with valid=1 and out=00 → out holds steady. Pulse in=0010 twice, 3 cycles apart → overflow=1 for one cycle after the second pulse. On raising ready, grants are 00 then 01 only.
5. pending=1110, valid=1, rst high for one edge → the next cycle shows pending=0000, valid=0, out=00, overflow=0. With in=0 afterward, no valid appears for 10 cycles.
6. pending=0100 only, valid=0, and in=0100 pulsed on the load edge → two grants of out=10, overflow=0.
